// File: rtl/serial_parity_tx_pkg.sv
// Shared types and constants for the serial parity transmitter.
package serial_parity_tx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Width of a counter able to index every data bit of a word.
    function automatic int unsigned bit_cnt_width(input int unsigned data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR primitive.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/serial_parity_tx.sv
// Parallel-to-serial transmitter: LSB-first data beats followed by one parity beat.
module serial_parity_tx
    import serial_parity_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ser_out,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  frame_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

    localparam int unsigned BIT_CNT_W = bit_cnt_width(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic [CNT_WIDTH-1:0]   frames_q, frames_d;
    logic                   in_ready_q, in_ready_d;
    logic                   ser_out_q, ser_out_d;
    logic                   ser_valid_q, ser_valid_d;
    logic                   frame_last_q, frame_last_d;
    logic                   busy_q, busy_d;
    logic                   parity_next_c;

    // Running parity term: accumulator folded with the bit leaving this beat.
    xor_gate u_parity_xor (
        .a (parity_q),
        .b (shift_q[0]),
        .y (parity_next_c)
    );

    // Next-state datapath and output decode from the upcoming state.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_d     = parity_q;
        frames_d     = frames_q;
        in_ready_d   = 1'b0;
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        frame_last_d = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                    parity_d  = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (ser_ready) begin
                    parity_d  = parity_next_c;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (ser_ready) begin
                    frames_d = frames_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE: begin
                in_ready_d = 1'b1;
            end
            DATA: begin
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
                ser_out_d   = shift_d[0];
            end
            PARITY: begin
                ser_valid_d  = 1'b1;
                busy_d       = 1'b1;
                frame_last_d = 1'b1;
                ser_out_d    = parity_d ^ ODD_PARITY;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            frames_q     <= '0;
            in_ready_q   <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            frames_q     <= frames_d;
            in_ready_q   <= in_ready_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_last  = frame_last_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_serial_parity_tx.sv
// Scoreboard bench: three transmitters (even, odd, 2-bit counter) share one stimulus stream.
module tb_serial_parity_tx;

    localparam int unsigned NI    = 3;
    localparam int unsigned DEPTH = 1024;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic [NI-1:0] in_ready_a;
    logic [NI-1:0] ser_out_a;
    logic [NI-1:0] ser_valid_a;
    logic [NI-1:0] frame_last_a;
    logic [NI-1:0] busy_a;
    logic [15:0]   fs0;
    logic [15:0]   fs1;
    logic [1:0]    fs2;
    logic [15:0]   fs_a [NI];

    assign fs_a[0] = fs0;
    assign fs_a[1] = fs1;
    assign fs_a[2] = {14'd0, fs2};

    serial_parity_tx #(.DATA_WIDTH(8), .ODD_PARITY(1'b0), .CNT_WIDTH(16)) u_even (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a[0]), .ser_out(ser_out_a[0]), .ser_valid(ser_valid_a[0]),
        .ser_ready(ser_ready), .frame_last(frame_last_a[0]), .busy(busy_a[0]),
        .frames_sent(fs0)
    );

    serial_parity_tx #(.DATA_WIDTH(8), .ODD_PARITY(1'b1), .CNT_WIDTH(16)) u_odd (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a[1]), .ser_out(ser_out_a[1]), .ser_valid(ser_valid_a[1]),
        .ser_ready(ser_ready), .frame_last(frame_last_a[1]), .busy(busy_a[1]),
        .frames_sent(fs1)
    );

    serial_parity_tx #(.DATA_WIDTH(8), .ODD_PARITY(1'b0), .CNT_WIDTH(2)) u_wrap (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a[2]), .ser_out(ser_out_a[2]), .ser_valid(ser_valid_a[2]),
        .ser_ready(ser_ready), .frame_last(frame_last_a[2]), .busy(busy_a[2]),
        .frames_sent(fs2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, one set per instance.
    logic [7:0] words [NI][DEPTH];
    int         wr_ptr  [NI];
    int         rd_ptr  [NI];
    int         beat    [NI];
    int         exp_cnt [NI];
    int         cnt_mod [NI];
    int         odd_par [NI];
    logic       rst_prev = 1'b1;
    int         ready_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Expected parity from the ones count of the word.
    function automatic logic exp_parity(input logic [7:0] w, input int odd);
        return 1'((($countones(w) % 2) + odd) % 2);
    endfunction

    // Monitor: compares each instance against the model, away from the active edge.
    initial begin
        for (int i = 0; i < int'(NI); i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; beat[i] = 0; exp_cnt[i] = 0;
        end
        cnt_mod = '{65536, 65536, 4};
        odd_par = '{0, 1, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < int'(NI); i++) begin
                logic       pending;
                logic [7:0] w;
                logic       eb;
                logic       el;
                pending = (rd_ptr[i] != wr_ptr[i]);
                w  = words[i][rd_ptr[i] % DEPTH];
                el = (beat[i] == 8);
                eb = el ? exp_parity(w, odd_par[i]) : w[beat[i] % 8];
                chk("ser_valid", i, 32'(ser_valid_a[i]), 32'(pending));
                chk("busy", i, 32'(busy_a[i]), 32'(pending));
                chk("in_ready", i, 32'(in_ready_a[i]), 32'(!pending && !rst_prev));
                chk("frames_sent", i, 32'(fs_a[i]), 32'(exp_cnt[i]));
                if (pending) begin
                    chk("ser_out", i, 32'(ser_out_a[i]), 32'(eb));
                    chk("frame_last", i, 32'(frame_last_a[i]), 32'(el));
                end else begin
                    chk("frame_last_idle", i, 32'(frame_last_a[i]), 32'd0);
                    if (rst_prev) chk("ser_out_rst", i, 32'(ser_out_a[i]), 32'd0);
                end
                if (rst) begin
                    rd_ptr[i]  = wr_ptr[i];
                    beat[i]    = 0;
                    exp_cnt[i] = 0;
                end else if (pending) begin
                    if (ser_ready) begin
                        beat[i]++;
                        if (beat[i] == 9) begin
                            beat[i]    = 0;
                            rd_ptr[i]++;
                            exp_cnt[i] = (exp_cnt[i] + 1) % cnt_mod[i];
                        end
                    end
                end else if (!rst_prev && in_valid) begin
                    words[i][wr_ptr[i] % DEPTH] = in_data;
                    wr_ptr[i]++;
                end
            end
            rst_prev = rst;
        end
    end

    // Downstream ready: always, random, or the 1,0,0 stall pattern.
    initial begin
        int k = 0;
        ser_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ser_ready = 1'b1;
                1:       ser_ready = 1'($urandom_range(0, 1));
                default: ser_ready = (k % 3 == 0);
            endcase
            k++;
        end
    end

    // Offer a word and wait (bounded) until the handshake edge has passed.
    task automatic send(input logic [7:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_a[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL handshake_timeout got=busy exp=in_ready t=%0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready_a[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL idle_timeout got=busy exp=idle t=%0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed words, full throughput, back-to-back (also wraps the 2-bit counter).
        ready_mode = 0;
        send(8'hA5);
        send(8'h07);
        send(8'h00);
        send(8'h81);
        send(8'hFE);
        wait_idle();

        // Backpressure with the 1,0,0 stall pattern.
        ready_mode = 2;
        send(8'h3C);
        wait_idle();

        // Reset during beat 4 of 8'hFF, then a clean frame.
        ready_mode = 0;
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(8'h01);
        wait_idle();

        // in_valid held high with changing data while a frame is in flight.
        send(8'h5A);
        in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Random words, random downstream stalls, random gaps.
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
